// File: rtl/randn_seq_ctrl.sv
// Sequencer for the 8-bit subtractive lagged-Fibonacci noise source (lags 55/24).
// Owns the lag store, serial seed load/validation, warm-up discard and valid/ready streaming.
module randn_seq_ctrl #(
    parameter int unsigned WARMUP = 110
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       seed_we,
    input  logic [7:0] seed_data,
    input  logic       start,
    input  logic       stop,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic [1:0] state,
    output logic [5:0] seed_cnt,
    output logic       busy,
    output logic       seed_err
);

    localparam int          LAGS     = 55;
    localparam int          TAP      = 24;
    localparam logic [5:0]  SEED_MAX = 6'd55;
    localparam logic [15:0] WARMUP_W = 16'(WARMUP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WARM = 2'd2,
        ST_RUN  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  seed_cnt_q, seed_cnt_d;
    logic        odd_q, odd_d;
    logic [15:0] warm_cnt_q, warm_cnt_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        busy_q, busy_d;
    logic        seed_err_q, seed_err_d;

    // lag_q[k-1] holds X_k
    logic [7:0]  lag_q [LAGS];
    logic [7:0]  lag_d [LAGS];

    logic        shift_en;
    logic [7:0]  shift_word;
    logic [7:0]  step_word;
    logic        start_ok;

    assign step_word = lag_q[LAGS-1] - lag_q[TAP-1];
    assign start_ok  = start && !stop;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        seed_cnt_d  = seed_cnt_q;
        odd_d       = odd_q;
        warm_cnt_d  = warm_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        seed_err_d  = seed_err_q;
        shift_en    = 1'b0;
        shift_word  = step_word;

        case (state_q)
            ST_IDLE: begin
                if (seed_we) begin
                    // Seeding from IDLE always begins a fresh sequence
                    shift_en   = 1'b1;
                    shift_word = seed_data;
                    seed_cnt_d = 6'd1;
                    odd_d      = seed_data[0];
                    state_d    = ST_LOAD;
                end else if (start_ok) begin
                    if (seed_cnt_q == SEED_MAX && odd_q) begin
                        warm_cnt_d = WARMUP_W;
                        state_d    = (WARMUP_W == 16'd0) ? ST_RUN : ST_WARM;
                    end else begin
                        seed_err_d = 1'b1;
                    end
                end
            end

            ST_LOAD: begin
                if (seed_we) begin
                    shift_en   = 1'b1;
                    shift_word = seed_data;
                    seed_cnt_d = seed_cnt_q + 6'd1;
                    odd_d      = odd_q | seed_data[0];
                    if (seed_cnt_q == SEED_MAX - 6'd1) begin
                        state_d = ST_IDLE;
                    end
                end
                if (start_ok) begin
                    seed_err_d = 1'b1;
                end
            end

            ST_WARM: begin
                if (seed_we) begin
                    seed_err_d = 1'b1;
                end
                if (stop) begin
                    state_d = ST_IDLE;
                end else begin
                    shift_en   = 1'b1;
                    warm_cnt_d = warm_cnt_q - 16'd1;
                    if (warm_cnt_q <= 16'd1) begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (seed_we) begin
                    seed_err_d = 1'b1;
                end
                if (stop) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end else if (!out_valid_q || out_ready) begin
                    shift_en    = 1'b1;
                    out_data_d  = step_word;
                    out_valid_d = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_WARM) || (state_d == ST_RUN);

        lag_d = lag_q;
        if (shift_en) begin
            lag_d[0] = shift_word;
            for (int k = 1; k < LAGS; k++) begin
                lag_d[k] = lag_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            seed_cnt_q  <= 6'd0;
            odd_q       <= 1'b0;
            warm_cnt_q  <= 16'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
            busy_q      <= 1'b0;
            seed_err_q  <= 1'b0;
            // NOTE: the lag store is cleared on reset, so it is built from flops rather than a RAM.
            for (int k = 0; k < LAGS; k++) begin
                lag_q[k] <= 8'd0;
            end
        end else begin
            state_q     <= state_d;
            seed_cnt_q  <= seed_cnt_d;
            odd_q       <= odd_d;
            warm_cnt_q  <= warm_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            seed_err_q  <= seed_err_d;
            for (int k = 0; k < LAGS; k++) begin
                lag_q[k] <= lag_d[k];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign state     = state_q;
    assign seed_cnt  = seed_cnt_q;
    assign busy      = busy_q;
    assign seed_err  = seed_err_q;

endmodule

// File: tb/tb_randn_seq_ctrl.sv
// Bench for randn_seq_ctrl: two instances (WARMUP=0 and WARMUP=3) share stimulus;
// directed sequences plus a per-cycle vector table for the streaming phase.
module tb_randn_seq_ctrl;

    logic       clk = 1'b0;
    logic       RESET;
    logic       seed_we;
    logic [7:0] seed_data;
    logic       start;
    logic       stop;
    logic       out_ready;

    logic       v0, v3;
    logic [7:0] d0, d3;
    logic [1:0] st0, st3;
    logic [5:0] cnt0, cnt3;
    logic       busy0, busy3;
    logic       err0, err3;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference sequence: x[0..54] are the seeds in write order, x[n] = x[n-55] - x[n-24].
    logic [7:0] ref_s [0:127];

    typedef struct {
        int ready, start, stop, we;
        int exp_valid, exp_idx, exp_state, exp_err;
        int exp3_state, exp3_valid, exp3_idx;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    randn_seq_ctrl #(.WARMUP(0)) dut0 (
        .clk(clk), .RESET(RESET), .seed_we(seed_we), .seed_data(seed_data),
        .start(start), .stop(stop), .out_ready(out_ready),
        .out_valid(v0), .out_data(d0), .state(st0), .seed_cnt(cnt0),
        .busy(busy0), .seed_err(err0)
    );

    randn_seq_ctrl #(.WARMUP(3)) dut3 (
        .clk(clk), .RESET(RESET), .seed_we(seed_we), .seed_data(seed_data),
        .start(start), .stop(stop), .out_ready(out_ready),
        .out_valid(v3), .out_data(d3), .state(st3), .seed_cnt(cnt3),
        .busy(busy3), .seed_err(err3)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        seed_we   = 1'b0;
        seed_data = 8'd0;
        start     = 1'b0;
        stop      = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    task automatic write_seed(input logic [7:0] w);
        seed_we   = 1'b1;
        seed_data = w;
        tick();
        seed_we   = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state0"}, st0, 0);
        check({tag, "_cnt0"}, cnt0, 0);
        check({tag, "_valid0"}, v0, 0);
        check({tag, "_data0"}, d0, 0);
        check({tag, "_busy0"}, busy0, 0);
        check({tag, "_err0"}, err0, 0);
        check({tag, "_state3"}, st3, 0);
        check({tag, "_valid3"}, v3, 0);
    endtask

    function automatic void add(int r, int st, int sp, int we, int v, int idx, int s, int e,
                                int s3, int v3e, int i3);
        vec_t t;
        t = '{ready: r, start: st, stop: sp, we: we, exp_valid: v, exp_idx: idx,
              exp_state: s, exp_err: e, exp3_state: s3, exp3_valid: v3e, exp3_idx: i3};
        vecs.push_back(t);
    endfunction

    initial begin
        for (int i = 0; i < 55; i++) ref_s[i] = 8'(i + 1);
        for (int n = 55; n < 128; n++) ref_s[n] = ref_s[n-55] - ref_s[n-24];

        // Streaming table, one row per edge after the start edge.
        add(1,0,0,0, 1,0,3,0, 2,0,-1);
        add(1,0,0,0, 1,1,3,0, 2,0,-1);
        add(1,0,0,0, 1,2,3,0, 3,0,-1);
        for (int i = 3; i <= 27; i++) add(1,0,0,0, 1,i,3,0, 3,1,i);
        for (int i = 0; i < 5; i++)   add(0,0,0,0, 1,27,3,0, 3,1,27);
        for (int i = 28; i <= 31; i++) add(1,0,0,0, 1,i,3,0, 3,1,i);
        add(1,0,0,1, 1,32,3,1, 3,1,32);
        add(1,0,0,0, 1,33,3,1, 3,1,33);
        add(1,0,0,0, 1,34,3,1, 3,1,34);
        add(1,0,1,0, 0,-1,0,1, 0,0,-1);
        add(1,1,0,0, 0,-1,3,1, 2,0,-1);
        add(1,0,0,0, 1,35,3,1, 2,0,-1);
        add(1,0,0,0, 1,36,3,1, 2,0,-1);
        add(1,0,0,0, 1,37,3,1, 3,0,-1);
        add(1,0,0,0, 1,38,3,1, 3,1,38);

        out_ready = 1'b0;
        idle_inputs();
        RESET = 1'b1;
        tick();
        tick();
        check_reset_vals("reset");
        RESET = 1'b0;

        // All-even seed: rejected on start
        for (int i = 0; i < 55; i++) write_seed(8'd0);
        check("zero_cnt", cnt0, 55);
        check("zero_state_pre", st0, 0);
        start = 1'b1; tick(); start = 1'b0;
        check("zero_err", err0, 1);
        check("zero_state", st0, 0);

        // Short seed: start in LOAD flags error, count kept
        do_reset();
        check("rst_err_clear", err0, 0);
        for (int i = 0; i < 20; i++) write_seed(8'(i + 1));
        check("short_state", st0, 1);
        start = 1'b1; tick(); start = 1'b0;
        check("short_err", err0, 1);
        check("short_cnt", cnt0, 20);

        // Good seed 1..55; first write coincides with start (seed_we wins, no error)
        do_reset();
        seed_we = 1'b1; seed_data = 8'd1; start = 1'b1;
        tick();
        idle_inputs();
        check("sw_start_cnt", cnt0, 1);
        check("sw_start_state", st0, 1);
        check("sw_start_err", err0, 0);
        for (int i = 2; i <= 55; i++) write_seed(8'(i));
        check("seed_cnt_full", cnt0, 55);
        check("seed_state_idle", st0, 0);
        check("seed_err_none", err0, 0);

        // start and stop together in IDLE
        start = 1'b1; stop = 1'b1; tick(); idle_inputs();
        check("race_state", st0, 0);
        check("race_err", err0, 0);
        check("race_busy", busy0, 0);

        out_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        check("start_state0", st0, 3);
        check("start_busy0", busy0, 1);
        check("start_valid0", v0, 0);
        check("start_state3", st3, 2);
        check("start_busy3", busy3, 1);

        foreach (vecs[i]) begin
            out_ready = vecs[i].ready[0];
            start     = vecs[i].start[0];
            stop      = vecs[i].stop[0];
            seed_we   = vecs[i].we[0];
            seed_data = 8'hA5;
            tick();
            check($sformatf("row%0d_valid0", i), v0, vecs[i].exp_valid);
            check($sformatf("row%0d_state0", i), st0, vecs[i].exp_state);
            check($sformatf("row%0d_busy0", i), busy0, (vecs[i].exp_state >= 2) ? 1 : 0);
            check($sformatf("row%0d_err0", i), err0, vecs[i].exp_err);
            check($sformatf("row%0d_cnt0", i), cnt0, 55);
            if (vecs[i].exp_idx >= 0)
                check($sformatf("row%0d_data0", i), d0, ref_s[55 + vecs[i].exp_idx]);
            check($sformatf("row%0d_state3", i), st3, vecs[i].exp3_state);
            check($sformatf("row%0d_valid3", i), v3, vecs[i].exp3_valid);
            check($sformatf("row%0d_err3", i), err3, vecs[i].exp_err);
            if (vecs[i].exp3_idx >= 0)
                check($sformatf("row%0d_data3", i), d3, ref_s[55 + vecs[i].exp3_idx]);
        end
        idle_inputs();

        // Reset mid-run overrides simultaneous inputs
        RESET = 1'b1; seed_we = 1'b1; start = 1'b1; stop = 1'b1; seed_data = 8'h33;
        tick();
        RESET = 1'b0;
        idle_inputs();
        check_reset_vals("midrst");
        start = 1'b1; tick(); start = 1'b0;
        check("midrst_start_err", err0, 1);
        check("midrst_start_state", st0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/randn_seq_ctrl.md
# randn_seq_ctrl

Sequencer for the 8-bit subtractive lagged-Fibonacci noise source used by the imitator DSP path (lags 55/24, x[n] = x[n-55] - x[n-24] mod 256). It owns the 55-word lag store. It loads a run-time seed serially, validates the seed, and runs a programmable warm-up discard. It then streams samples to the consumer over a valid/ready handshake, with start/stop control from the imitator configuration logic.

## Interface
- WARMUP, 110, number of generator steps discarded after start (0..65535; 0 = no warm-up)
- clk  in  1  system clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- seed_we  in  1  seed word write strobe
- seed_data  in  8  seed word
- start  in  1  start request (pulse)
- stop  in  1  stop request (pulse)
- out_ready  in  1  consumer ready
- out_valid  out  1  sample valid
- out_data  out  8  sample
- state  out  2  FSM state: 0 IDLE, 1 LOAD, 2 WARM, 3 RUN
- seed_cnt  out  6  seed words loaded (0..55)
- busy  out  1  high in WARM or RUN
- seed_err  out  1  sticky error flag

## Operation
- **Lag store and step:**
  - Lag store is X_1..X_55, each 8 bit.
  - One step computes new = X_55 - X_24, truncated to 8 bits (natural wrap).
  - Then X_k <= X_(k-1) for k = 2..55, and X_1 <= new.
- **Seeding:**
  - Allowed only in IDLE or LOAD.
  - Each seed_we shifts seed_data into X_1 with the same shift as a step, and increments seed_cnt.
  - After 55 writes, the first word written is in X_55 and the last is in X_1.
  - Odd flag: set if any loaded word has bit 0 = 1; cleared when a new seed sequence begins.
- **IDLE:**
  - seed_we with seed_cnt = 0 or 55: seed_cnt <= 1, odd flag restarts from this word, go to LOAD.
  - start with seed_cnt = 55 and odd flag set: load the warm-up counter with WARMUP, go to WARM, or go to RUN directly if WARMUP = 0.
  - start with seed_cnt < 55 or odd flag clear: seed_err <= 1, stay in IDLE.
- **LOAD:**
  - seed_we increments seed_cnt; on reaching 55, return to IDLE.
  - start in LOAD: seed_err <= 1.
  - stop ignored.
- **WARM:**
  - One step per cycle, output discarded; counter decrements.
  - After WARMUP steps, go to RUN.
  - stop: go to IDLE.
- **RUN:**
  - A step occurs when !out_valid || out_ready.
  - On a step: out_data <= new, out_valid <= 1.
  - stop: go to IDLE, out_valid <= 0; the lag store is retained.
- **Restart:** a later start from IDLE (seed_cnt still 55) re-runs warm-up from the retained state.
- **seed_err sets:**
  - seed_we in WARM or RUN: ignored, seed_err <= 1.
  - Only RESET clears seed_err.
- **Simultaneous events:**
  - stop and start together: stop wins, start ignored.
  - seed_we and start together in IDLE: seed_we wins, start ignored with no error.
- **Reset values:**
  - state IDLE; seed_cnt 0; odd flag 0; warm-up counter 0.
  - out_valid 0; out_data 0; busy 0; seed_err 0.
  - Lag store all zero.
- **RESET mid-operation:** overrides all inputs the same cycle; seeding must be repeated.

## Timing
- Seed word written at edge t is in X_1 after edge t.
- Start accepted at edge t:
  - State changes after edge t.
  - With WARMUP = N, steps occur at edges t+1..t+N, and state = RUN after edge t+N.
  - First out_valid = 1 after edge t+1+N.
- Throughput: one sample per cycle while out_ready = 1. No bubble on a continuous handshake.
- Backpressure: while out_valid && !out_ready, out_data, out_valid and the lag store are frozen.
- stop at edge t: state = IDLE and out_valid = 0 after edge t. A pending unaccepted sample is dropped.
- busy and state are registered, consistent with the FSM after each edge.

## Test plan
- **Basic generation.** WARMUP = 0; write seeds 1,2,...,55 (so X_55 = 1, X_24 = 32); start; out_ready = 1.
  - Expect out_valid after 2 edges.
  - First 24 samples all 225; seed_err = 0.
- **Warm-up latency.** WARMUP = 3, same seed, start at edge t.
  - state = WARM after t, RUN after t+3, first out_valid after t+4.
  - First sample equals the 4th sample of the WARMUP = 0 run.
- **Backpressure.** Basic run with out_ready held 0 for 5 cycles mid-stream.
  - out_data constant, no sample lost or duplicated versus the free-running reference sequence.
- **Seed validation.**
  - 55 zero words, then start: seed_err = 1, state stays IDLE.
  - 20 words, then start: seed_err = 1, seed_cnt = 20.
  - seed_we during RUN: seed_err = 1, stream unaffected.
- **Control races.**
  - start and stop on the same edge in IDLE: stays IDLE, no error.
  - stop in RUN: out_valid drops next edge; a later start resumes from the retained lag store after warm-up.
- **Reset mid-run.** RESET asserted during RUN.
  - Next edge: all outputs at reset values, seed_cnt = 0.
  - start without reseeding sets seed_err.
